regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file for the rv32i core: `NREAD` asynchronous read ports and one synchronous write port. It adds optional same-cycle write-to-read bypass, a hard-wired zero register, and a sequential clear engine that sweeps every entry to zero after reset or on request. It sits between decode (read addresses) and writeback (write port), and the core's stall logic consumes `busy`/`wready`.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `NREGS`, default 32: number of entries, 2..256; need not be a power of two.
- `AW`, default `$clog2(NREGS)`: address width.
- `NREAD`, default 2: number of read ports, 1..4.
- `ZERO_REG`, default 1: when 1, entry 0 reads as 0 and writes to it are dropped.
- `BYPASS`, default 0: when 1, an accepted write is forwarded to matching read ports in the same cycle.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `raddr`  in  `NREAD*AW`  — read addresses; port i uses bits `[i*AW +: AW]`.
- `rdata`  out  `NREAD*XLEN`  — read data; port i uses bits `[i*XLEN +: XLEN]`.
- `we`  in  1  — write request.
- `waddr`  in  `AW`  — write address.
- `wdata`  in  `XLEN`  — write data.
- `wready`  out  1  — write port available; equals `!busy`.
- `clear_req`  in  1  — request a full clear sweep.
- `busy`  out  1  — clear sweep in progress.
- `clear_done`  out  1  — one-cycle pulse when a sweep completes.

## Operation
- Storage: array of `NREGS` x `XLEN`, no reset on the array itself.
- Write acceptance: a write is accepted when `we && wready`. It commits at the rising edge, except when `waddr >= NREGS` or when `ZERO_REG && waddr==0`; those writes are dropped silently.
- Read ports are combinational from `raddr`. Port i returns 0 when any of these holds:
  - `ZERO_REG` and `raddr_i==0`;
  - `raddr_i >= NREGS`;
  - `busy`.
- Otherwise, if `BYPASS` is set and an accepted, non-dropped write has `waddr==raddr_i`, the port returns `wdata`. Otherwise it returns the array contents.
- FSM states: `CLEAR`, `IDLE`.
  - `CLEAR`: index counter `idx` writes 0 to `mem[idx]` on each edge and increments. On the edge where `idx==NREGS-1`, the FSM goes to `IDLE`, `idx` goes to 0, and `clear_done` registers 1.
  - `IDLE`: if `clear_req`=1 at an edge, the FSM goes to `CLEAR` with `idx=0`.
- `busy` is 1 exactly while the state is `CLEAR`.
- `clear_req` is ignored while in `CLEAR`; a sweep is never restarted and requests are not queued.
- Simultaneous `clear_req` and `we` in `IDLE`: the write is accepted and committed at that edge, then the sweep erases it.
- `idx` width is `AW`; no wrap-around beyond `NREGS-1`.

## Timing
Reset values:
- State `CLEAR`, `idx`=0.
- `busy`=1, `wready`=0, `clear_done`=0.
- `rdata` = all zeros (forced by `busy`).

Reset behaviour:
- `rst_n` low at any time, including mid-sweep or mid-write, forces the reset values immediately.
- Deassertion starts a fresh sweep from `idx`=0.

Latencies:
- Read: 0 cycles (combinational).
- Write: visible via the array one cycle after the accepting edge. With `BYPASS=1` it is also visible in the accepting cycle.
- Sweep: `busy` stays high for exactly `NREGS` rising edges after reset release or after the edge that accepts `clear_req`.
- `clear_done` is high for the one cycle following the last sweep edge, coincident with the first `wready`=1 cycle.

Other rules:
- Multiple read ports with the same address return identical data.
- A read of the same address as a write in the same cycle with `BYPASS=0` returns the old value.

## Test plan
1. **Reset sweep.** NREGS=32. Release `rst_n` with `we`=1 held.
   - `busy`=1 and `rdata`=0 for 32 edges.
   - `clear_done` pulses once; `wready` rises in the same cycle.
   - No write lands before `wready`.
2. **Basic write/read.** Write 0xDEADBEEF to r5, then read r5 on both ports → 0xDEADBEEF on both the next cycle. Write 0x12345678 to r0 → r0 still reads 0.
3. **Bypass.**
   - `BYPASS=1`: write 0xA5A5A5A5 to r7 while `raddr0`=7 → `rdata0`=0xA5A5A5A5 in the same cycle.
   - `BYPASS=0`: the same stimulus → old value that cycle, new value the next.
4. **Non-power-of-two depth.** NREGS=24: write 0x1 to addr 30 → dropped. Reading addr 30 → 0. Addr 23 stays writable.
5. **Clear request collisions.**
   - In `IDLE`, assert `clear_req` with a write of 0x55 to r3 → after 32 cycles r3 reads 0.
   - Assert `clear_req` again mid-sweep → sweep length is unchanged and only one `clear_done` pulse occurs.
6. **Reset mid-sweep.** Pull `rst_n` low at `idx`=10 → outputs return to reset values immediately. After release, a full 32-cycle sweep runs from `idx`=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports, one write port,
// optional write-to-read bypass, hard-wired zero register and a sequential clear sweep.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    output logic                  wready,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_commit;
    logic [AW-1:0]   ra;

    // Address is backed by storage and is not the hard-wired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS)) && !(ZERO_REG && (a == '0));
    endfunction

    assign busy      = (state == CLEAR);
    assign wready    = !busy;
    assign wr_commit = we && wready && addr_ok(waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            idx        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        idx        <= '0;
                        clear_done <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep owns the array while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[idx] <= '0;
        end else if (wr_commit) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = raddr[i*AW +: AW];
            if (!busy && addr_ok(ra)) begin
                if (BYPASS && wr_commit && (waddr == ra)) begin
                    rdata[i*XLEN +: XLEN] = wdata;
                end else begin
                    rdata[i*XLEN +: XLEN] = mem[ra];
                end
            end
        end
    end

endmodule
